pipe_stage_fifo: RTL and testbench

- Elastic buffer between two 16-bit pipeline stages. It absorbs producer/consumer rate mismatch so that a downstream stall does not drop words.
- It sits directly upstream of the half-cycle word forwarder registers and feeds them one word per accepted handshake.
- Valid/ready handshake on both sides. First-word-fall-through read, flush for pipeline squash, occupancy output for hazard logic.

---
 rtl/pipe_stage_fifo.sv | 89 ++++++++
 tb/tb_pipe_stage_fifo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: elastic buffer between two WIDTH-bit pipeline stages.
// Valid/ready on both sides, first-word-fall-through read, synchronous
// flush for pipeline squash, and an occupancy count for hazard logic.
// Full/empty are decided from the occupancy count alone, so the pointers
// are free to wrap silently.
module pipe_stage_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ZERO_COUNT = (AW + 1)'(0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [AW:0]      count_next;

  // Handshake qualification; in_ready depends only on stored state, never on out_ready.
  always_comb begin
    in_ready  = (count != FULL_COUNT);
    out_valid = (count != ZERO_COUNT);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // First-word-fall-through read of the oldest entry; zero while empty.
  always_comb begin
    if (out_valid) begin
      out_word = mem[rd_ptr];
    end else begin
      out_word = {WIDTH{1'b0}};
    end
  end

  // Occupancy change for this edge: simultaneous push and pop cancel out.
  always_comb begin
    case ({push, pop})
      2'b10:   count_next = count + (AW + 1)'(1);
      2'b01:   count_next = count - (AW + 1)'(1);
      2'b11:   count_next = count;
      2'b00:   count_next = count;
      default: count_next = count;
    endcase
  end

  // Pointer and occupancy registers; reset outranks flush, both discard everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= ZERO_COUNT;
    end else if (flush) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= ZERO_COUNT;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem[wr_ptr] <= in_word;
    end
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// tb_pipe_stage_fifo: scoreboard bench for pipe_stage_fifo (DEPTH=4, WIDTH=16).
// Each cycle the bench drives inputs, checks the settled outputs against
// its own queue model, then applies the edge to the model.
module tb_pipe_stage_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_word;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic [AW:0]      count;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  bit          checking   = 1'b0;
  logic [WIDTH-1:0] sb [$];

  pipe_stage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check settled outputs against the model, update the model.
  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [WIDTH-1:0] iw, input logic ordy);
    logic [WIDTH-1:0] exp_word;
    int               n;
    bit               do_push;
    rst = r; flush = f; in_valid = iv; in_word = iw; out_ready = ordy;
    #1;
    n = sb.size();
    if (checking) begin
      exp_word = (n != 0) ? sb[0] : 16'h0000;
      check("count",     32'(count),     32'(n));
      check("in_ready",  32'(in_ready),  32'(n != DEPTH));
      check("out_valid", 32'(out_valid), 32'(n != 0));
      check("out_word",  32'(out_word),  32'(exp_word));
    end
    if (r || f) begin
      sb.delete();
    end else begin
      do_push = iv && (n != DEPTH);
      if (ordy && (n != 0)) begin
        void'(sb.pop_front());
      end
      if (do_push) begin
        sb.push_back(iw);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then idle.
    cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    checking = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("idle_out_word", 32'(out_word), 32'h0000);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Fill to DEPTH with the consumer stalled; fifth word refused.
    cycle(1'b0, 1'b0, 1'b1, 16'h1111, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'h2222, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'h3333, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'h4444, 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
    check("refused_count", 32'(count), 32'd4);
    check("refused_head", 32'(out_word), 32'h1111);

    // Push while full and popping: push still refused.
    cycle(1'b0, 1'b0, 1'b1, 16'h5555, 1'b1);
    check("full_pop_count", 32'(count), 32'd3);
    check("full_pop_in_ready", 32'(in_ready), 32'd1);

    // Drain remaining three.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    end
    check("drained_count", 32'(count), 32'd0);
    check("drained_valid", 32'(out_valid), 32'd0);

    // Prime two words, then stream with push and pop together.
    cycle(1'b0, 1'b0, 1'b1, 16'h0B01, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0B02, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 16'h0A00 + 16'(i), 1'b1);
      check("stream_count", 32'(count), 32'd2);
    end

    // Third word, then flush with a push and pop offered.
    cycle(1'b0, 1'b0, 1'b1, 16'h0C03, 1'b0);
    check("pre_flush_count", 32'(count), 32'd3);
    cycle(1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Fall-through latency into an empty FIFO, consumer ready.
    cycle(1'b0, 1'b0, 1'b1, 16'hCAFE, 1'b1);
    check("cafe_valid", 32'(out_valid), 32'd1);
    check("cafe_word", 32'(out_word), 32'hCAFE);

    // Reset mid-stream with a push offered.
    cycle(1'b1, 1'b0, 1'b1, 16'hDEAD, 1'b0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_word", 32'(out_word), 32'h0000);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
